// File: rtl/boid_pkg.sv
// Shared definitions for the boid frame writer: video geometry, the FSM
// state encoding and a saturating counter helper.
package boid_pkg;

  localparam int VIDEO_WIDTH         = 32'd640;
  localparam int VIDEO_HEIGHT        = 32'd480;
  localparam int PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int PIXEL_ADDRESS_WIDTH = $clog2(PIXEL_COUNT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SWAP = 3'd1,
    ST_LOAD = 3'd2,
    ST_DRAW = 3'd3,
    ST_DONE = 3'd4
  } boid_state_e;

  // Increment an 8-bit counter, sticking at its maximum value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/boid_addr_calc.sv
// Purely combinational mapping of a pixel coordinate to its linear display
// RAM address. 640*y is built from two shifts so no multiplier is needed.
module boid_addr_calc #(
  parameter int ADDR_WIDTH = 19
) (
  input  logic [ADDR_WIDTH-1:0] px,
  input  logic [ADDR_WIDTH-1:0] py,
  output logic [ADDR_WIDTH-1:0] addr
);

  assign addr = px + (py << 9) + (py << 7);

endmodule

// File: rtl/boid_frame_writer.sv
// Draws MAX_BOIDS square sprites into the display back buffer once per
// frame_end pulse. Every output is driven from a register; pixel outputs are
// loaded from the next-state values so the first write lands in the first
// DRAW cycle.
// Optional feature: define BOID_CLIP_EN to suppress writes to pixels that
// fall outside the 640x480 visible area (timing is unchanged).
module boid_frame_writer
  import boid_pkg::*;
#(
  parameter int MAX_BOIDS  = 4,
  parameter int BOID_SIZE  = 2,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                                              clock,
  input  logic                                              CPU_RESETN,
  input  logic                                              frame_end,
  output logic [((MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1)-1:0] boid_sel,
  input  logic [9:0]                                        boid_x,
  input  logic [8:0]                                        boid_y,
  output logic                                              buf_swap,
  output logic                                              pix_we,
  output logic [ADDR_WIDTH-1:0]                             pix_addr,
  output logic                                              pix_data,
  output logic                                              busy,
  output logic                                              frame_done,
  output logic [7:0]                                        overrun_cnt
);

  localparam int SW = (MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1;
  localparam int DW = (BOID_SIZE > 1) ? $clog2(BOID_SIZE) : 1;
  localparam logic [SW-1:0] IDX_MAX = SW'(MAX_BOIDS - 1);
  localparam logic [DW-1:0] D_MAX   = DW'(BOID_SIZE - 1);

  boid_state_e          state_r, state_s;
  logic [SW-1:0]        idx_r, idx_s;
  logic [9:0]           x_r, x_s;
  logic [8:0]           y_r, y_s;
  logic [DW-1:0]        dx_r, dx_s, dy_r, dy_s;
  logic [10:0]          cx_s;
  logic [9:0]           cy_s;
  logic                 clip_s;
  logic                 we_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                 buf_swap_r, pix_we_r, busy_r, frame_done_r;
  logic [ADDR_WIDTH-1:0] pix_addr_r;
  logic [7:0]           overrun_r;

  // Next-state logic: frame sequencing, boid index and sprite offsets.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    x_s     = x_r;
    y_s     = y_r;
    dx_s    = dx_r;
    dy_s    = dy_r;
    case (state_r)
      ST_IDLE: begin
        idx_s = '0;
        if (frame_end) begin
          state_s = ST_SWAP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SWAP: begin
        idx_s   = '0;
        state_s = ST_LOAD;
      end
      ST_LOAD: begin
        x_s     = boid_x;
        y_s     = boid_y;
        dx_s    = '0;
        dy_s    = '0;
        state_s = ST_DRAW;
      end
      ST_DRAW: begin
        if (dx_r == D_MAX) begin
          dx_s = '0;
          if (dy_r == D_MAX) begin
            dy_s = '0;
            if (idx_r == IDX_MAX) begin
              state_s = ST_DONE;
            end else begin
              idx_s   = idx_r + SW'(1);
              state_s = ST_LOAD;
            end
          end else begin
            dy_s = dy_r + DW'(1);
          end
        end else begin
          dx_s = dx_r + DW'(1);
        end
      end
      ST_DONE: begin
        idx_s   = '0;
        state_s = ST_IDLE;
      end
      default: begin
        idx_s   = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Coordinates of the pixel the next cycle will write, widened for compare.
  assign cx_s = {1'b0, x_s} + 11'(dx_s);
  assign cy_s = {1'b0, y_s} + 10'(dy_s);

  boid_addr_calc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_calc (
    .px  (ADDR_WIDTH'(cx_s)),
    .py  (ADDR_WIDTH'(cy_s)),
    .addr(addr_s)
  );

  // Write qualification for the next cycle, with optional off-screen clipping.
  always_comb begin
    clip_s = 1'b0;
`ifdef BOID_CLIP_EN
    if ((cx_s >= 11'(VIDEO_WIDTH)) || (cy_s >= 10'(VIDEO_HEIGHT))) begin
      clip_s = 1'b1;
    end else begin
      clip_s = 1'b0;
    end
`endif
    we_s = (state_s == ST_DRAW) && !clip_s;
  end

  // State, sprite registers and all registered outputs.
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      x_r          <= 10'd0;
      y_r          <= 9'd0;
      dx_r         <= '0;
      dy_r         <= '0;
      buf_swap_r   <= 1'b0;
      pix_we_r     <= 1'b0;
      pix_addr_r   <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 8'd0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      x_r          <= x_s;
      y_r          <= y_s;
      dx_r         <= dx_s;
      dy_r         <= dy_s;
      buf_swap_r   <= (state_s == ST_SWAP);
      pix_we_r     <= we_s;
      busy_r       <= (state_s != ST_IDLE);
      frame_done_r <= (state_s == ST_DONE);
      if (we_s) begin
        pix_addr_r <= addr_s;
      end
      if (frame_end && (state_r != ST_IDLE)) begin
        overrun_r <= sat_inc8(overrun_r);
      end
    end
  end

  assign boid_sel    = idx_r;
  assign buf_swap    = buf_swap_r;
  assign pix_we      = pix_we_r;
  assign pix_addr    = pix_addr_r;
  assign pix_data    = 1'b1;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign overrun_cnt = overrun_r;

endmodule

// File: tb/tb_boid_frame_writer.sv
// Directed self-checking bench for boid_frame_writer (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_boid_frame_writer;

  logic        clock = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic        frame_end = 1'b0;
  logic [1:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic        buf_swap, pix_we, pix_data, busy, frame_done;
  logic [18:0] pix_addr;
  logic [7:0]  overrun_cnt;

  logic [9:0]  bx [4];
  logic [8:0]  by [4];

  int checks = 0;
  int fails  = 0;
  int addr_q[$];
  int first_we, swap_cyc, swap_cnt, done_cyc, done_cnt, busy_cnt;

  int exp_main [16] = '{6410, 6411, 7050, 7051, 3220, 3221, 3860, 3861,
                        0, 1, 640, 641, 128100, 128101, 128740, 128741};
  int exp_edge [4]  = '{307199, 307200, 307839, 307840};

  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  always #10 clock = ~clock;

  boid_frame_writer #(.MAX_BOIDS(4), .BOID_SIZE(2), .ADDR_WIDTH(19)) dut (
    .clock(clock), .CPU_RESETN(CPU_RESETN), .frame_end(frame_end),
    .boid_sel(boid_sel), .boid_x(boid_x), .boid_y(boid_y),
    .buf_swap(buf_swap), .pix_we(pix_we), .pix_addr(pix_addr),
    .pix_data(pix_data), .busy(busy), .frame_done(frame_done),
    .overrun_cnt(overrun_cnt)
  );

  task automatic set_main_boids();
    bx[0] = 10'd10;  by[0] = 9'd10;
    bx[1] = 10'd20;  by[1] = 9'd5;
    bx[2] = 10'd0;   by[2] = 9'd0;
    bx[3] = 10'd100; by[3] = 9'd200;
  endtask

  // frame_end in cycle 0, optional extra pulse in cycle 'extra', observe ncyc cycles.
  task automatic run_frame(input int extra, input int ncyc);
    addr_q.delete();
    first_we = -1; swap_cyc = -1; swap_cnt = 0;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    @(negedge clock);
    frame_end = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      if (pix_we) begin
        addr_q.push_back(int'(pix_addr));
        if (first_we < 0) first_we = k;
      end
      if (buf_swap) begin swap_cnt++; swap_cyc = k; end
      if (frame_done) begin done_cnt++; done_cyc = k; end
      if (busy) busy_cnt++;
      frame_end = (k == extra);
    end
    frame_end = 1'b0;
  endtask

  task automatic test_reset();
    CPU_RESETN = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({boid_sel, buf_swap, pix_we, pix_addr, busy, frame_done, overrun_cnt} !== 34'd0) begin
      fails++;
      $display("FAIL reset_outputs: got sel=%0d swap=%0b we=%0b addr=%0d busy=%0b done=%0b ovr=%0d, expected all 0",
               boid_sel, buf_swap, pix_we, pix_addr, busy, frame_done, overrun_cnt);
    end
    checks++;
    if (pix_data !== 1'b1) begin
      fails++; $display("FAIL reset_pix_data: got %0b expected 1", pix_data);
    end
    CPU_RESETN = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_idle_busy: got %0b expected 0", busy);
    end
  endtask

  task automatic test_frame();
    set_main_boids();
    run_frame(-1, 30);
    checks++;
    if (addr_q.size() != 16) begin
      fails++; $display("FAIL frame_write_count: got %0d expected 16", addr_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= addr_q.size() || addr_q[i] != exp_main[i]) begin
        fails++;
        $display("FAIL frame_addr[%0d]: got %0d expected %0d", i,
                 (i < addr_q.size()) ? addr_q[i] : -1, exp_main[i]);
      end
    end
    checks++;
    if (swap_cnt != 1 || swap_cyc != 1) begin
      fails++; $display("FAIL frame_swap: got count %0d cycle %0d expected count 1 cycle 1", swap_cnt, swap_cyc);
    end
    checks++;
    if (first_we != 3) begin
      fails++; $display("FAIL frame_first_we: got cycle %0d expected 3", first_we);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 22) begin
      fails++; $display("FAIL frame_done: got count %0d cycle %0d expected count 1 cycle 22", done_cnt, done_cyc);
    end
    checks++;
    if (busy_cnt != 22) begin
      fails++; $display("FAIL frame_busy_cycles: got %0d expected 22", busy_cnt);
    end
    checks++;
    if (busy !== 1'b0 || boid_sel !== 2'd0 || pix_we !== 1'b0 || overrun_cnt !== 8'd0) begin
      fails++;
      $display("FAIL frame_end_state: got busy=%0b sel=%0d we=%0b ovr=%0d expected 0 0 0 0",
               busy, boid_sel, pix_we, overrun_cnt);
    end
    checks++;
    if (pix_addr !== 19'd128741) begin
      fails++; $display("FAIL frame_addr_hold: got %0d expected 128741", pix_addr);
    end
  endtask

  task automatic test_overrun();
    run_frame(5, 30);
    checks++;
    if (swap_cnt != 1 || addr_q.size() != 16 || done_cnt != 1) begin
      fails++;
      $display("FAIL overrun_single_frame: got swaps %0d writes %0d dones %0d expected 1 16 1",
               swap_cnt, addr_q.size(), done_cnt);
    end
    checks++;
    if (overrun_cnt !== 8'd1) begin
      fails++; $display("FAIL overrun_count: got %0d expected 1", overrun_cnt);
    end
  endtask

  task automatic test_done_coincident();
    run_frame(22, 30);
    checks++;
    if (overrun_cnt !== 8'd2) begin
      fails++; $display("FAIL done_coincident_overrun: got %0d expected 2", overrun_cnt);
    end
    checks++;
    if (swap_cnt != 1 || busy !== 1'b0) begin
      fails++; $display("FAIL done_coincident_swap: got swaps %0d busy %0b expected 1 0", swap_cnt, busy);
    end
  endtask

  task automatic test_clip();
    for (int b = 0; b < 4; b++) begin bx[b] = 10'd639; by[b] = 9'd479; end
    run_frame(-1, 30);
`ifdef BOID_CLIP_EN
    checks++;
    if (addr_q.size() != 4) begin
      fails++; $display("FAIL clip_write_count: got %0d expected 4", addr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= addr_q.size() || addr_q[i] != 307199) begin
        fails++;
        $display("FAIL clip_addr[%0d]: got %0d expected 307199", i, (i < addr_q.size()) ? addr_q[i] : -1);
      end
    end
`else
    checks++;
    if (addr_q.size() != 16) begin
      fails++; $display("FAIL noclip_write_count: got %0d expected 16", addr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= addr_q.size() || addr_q[i] != exp_edge[i]) begin
        fails++;
        $display("FAIL noclip_addr[%0d]: got %0d expected %0d", i, (i < addr_q.size()) ? addr_q[i] : -1, exp_edge[i]);
      end
    end
`endif
    checks++;
    if (done_cyc != 22) begin
      fails++; $display("FAIL clip_done_cycle: got %0d expected 22", done_cyc);
    end
  endtask

  task automatic test_reset_mid_frame();
    set_main_boids();
    @(negedge clock);
    frame_end = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      frame_end = 1'b0;
    end
    checks++;
    if (boid_sel !== 2'd2 || pix_we !== 1'b1) begin
      fails++; $display("FAIL mid_frame_pre_reset: got sel %0d we %0b expected 2 1", boid_sel, pix_we);
    end
    CPU_RESETN = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pix_we !== 1'b0 || busy !== 1'b0 || boid_sel !== 2'd0) begin
        fails++;
        $display("FAIL mid_frame_reset_held[%0d]: got we %0b busy %0b sel %0d expected 0 0 0", k, pix_we, busy, boid_sel);
      end
      @(negedge clock);
    end
    CPU_RESETN = 1'b1;
    run_frame(-1, 30);
    checks++;
    if (addr_q.size() != 16 || done_cyc != 22) begin
      fails++; $display("FAIL post_reset_frame: got writes %0d done cycle %0d expected 16 22", addr_q.size(), done_cyc);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= addr_q.size() || addr_q[i] != exp_main[i]) begin
        fails++;
        $display("FAIL post_reset_addr[%0d]: got %0d expected %0d", i, (i < addr_q.size()) ? addr_q[i] : -1, exp_main[i]);
      end
    end
  endtask

  task automatic test_saturate();
    @(negedge clock);
    frame_end = 1'b1;
    repeat (400) @(negedge clock);
    frame_end = 1'b0;
    repeat (40) @(negedge clock);
    checks++;
    if (overrun_cnt !== 8'd255) begin
      fails++; $display("FAIL overrun_saturate: got %0d expected 255", overrun_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL saturate_idle: got busy %0b expected 0", busy);
    end
  endtask

  initial begin
    set_main_boids();
    test_reset();
    test_frame();
    test_overrun();
    test_done_coincident();
    test_clip();
    test_reset_mid_frame();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
